// File: rtl/avg_unit_scheduler.sv
// Round-robin scheduler that shares one AvgUnit among NUM_REQ requesters, one transaction in flight.
// Optional: define AVG_SCHED_PERF_EN to add the 16-bit completed-transaction counter txn_count.
module avg_unit_scheduler #(
   parameter int DATA_WIDTH = 16,
   parameter int SIZE       = 4,
   parameter int NUM_REQ    = 4,
   parameter int ID_W       = 2,
   parameter int AVG_CYCLES = 8
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_REQ-1:0]                 req_valid,
   input  logic [NUM_REQ*DATA_WIDTH*SIZE-1:0] req_data,
   output logic [NUM_REQ-1:0]                 req_ready,
   output logic [DATA_WIDTH*SIZE-1:0]         avg_x,
   output logic                               avg_reset,
   input  logic [DATA_WIDTH-1:0]              avg_out,
   output logic                               resp_valid,
   input  logic                               resp_ready,
   output logic [ID_W-1:0]                    resp_id,
   output logic [DATA_WIDTH-1:0]              resp_data
`ifdef AVG_SCHED_PERF_EN
   ,
   output logic [15:0]                        txn_count
`endif
);

   localparam int VEC_W = DATA_WIDTH * SIZE;
   localparam int CNT_W = (AVG_CYCLES > 1) ? $clog2(AVG_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AVG_CYCLES - 1);
   localparam logic [ID_W-1:0]  PTR_RST  = ID_W'(NUM_REQ - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [VEC_W-1:0]      avg_x_q, avg_x_d;
   logic                  resp_valid_q, resp_valid_d;
   logic [ID_W-1:0]       resp_id_q, resp_id_d;
   logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;

   logic [VEC_W-1:0]      req_vec [NUM_REQ];
   logic                  grant_vld;
   logic [ID_W-1:0]       grant_idx;
   logic [ID_W-1:0]       cand;
   logic                  grant;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_vec[gi] = req_data[gi*VEC_W +: VEC_W];
   end

   // Scan from the farthest candidate down so the nearest one after rr_ptr wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (req_valid[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

   assign grant     = (state_q == S_IDLE) && !reset && grant_vld;
   assign req_ready = grant ? (NUM_REQ'(1) << grant_idx) : '0;

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      cnt_d        = cnt_q;
      avg_x_d      = avg_x_q;
      resp_valid_d = resp_valid_q;
      resp_id_d    = resp_id_q;
      resp_data_d  = resp_data_q;
      case (state_q)
         S_IDLE: begin
            if (grant) begin
               avg_x_d   = req_vec[grant_idx];
               resp_id_d = grant_idx;
               rr_ptr_d  = grant_idx;
               state_d   = S_CLEAR;
            end
         end
         S_CLEAR: begin
            cnt_d   = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (cnt_q == CNT_LAST) begin
               resp_data_d  = avg_out;
               resp_valid_d = 1'b1;
               state_d      = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         rr_ptr_q     <= PTR_RST;
         cnt_q        <= '0;
         avg_x_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         cnt_q        <= cnt_d;
         avg_x_q      <= avg_x_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_data_q  <= resp_data_d;
      end
   end

   // The unit is held in reset everywhere except while accumulating.
   assign avg_reset  = (state_q != S_RUN);
   assign avg_x      = avg_x_q;
   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;
   assign resp_data  = resp_data_q;

`ifdef AVG_SCHED_PERF_EN
   logic [15:0] txn_q, txn_d;

   always_comb begin
      txn_d = txn_q;
      if (resp_valid_q && resp_ready) begin
         txn_d = txn_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         txn_q <= '0;
      end else begin
         txn_q <= txn_d;
      end
   end

   assign txn_count = txn_q;
`endif

endmodule
